// File: rtl/fetch_assembler.sv
// Packs MEM_W-wide fetch beats into INST_W instructions and queues them in a
// DEPTH-entry FIFO. Define FETCH_FLUSH_CNT_EN to add the flush_cnt output.
module fetch_assembler #(
  parameter int MEM_W     = 8,
  parameter int INST_W    = 32,
  parameter int DEPTH     = 4,
  parameter int FLUSH_GAP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       if_pc,
  input  logic [MEM_W-1:0]  if_data,
  input  logic              if_valid,
  input  logic              jump,
  input  logic              id_ready,
  output logic              if_request,
  output logic              id_valid,
  output logic [INST_W-1:0] id_inst,
  output logic [31:0]       id_pc,
  output logic              if_stall_req
`ifdef FETCH_FLUSH_CNT_EN
  ,
  output logic [15:0]       flush_cnt
`endif
);

  localparam int BEATS = INST_W / MEM_W;
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);

  if (!(MEM_W == 8 || MEM_W == 16 || MEM_W == 32)) begin : g_bad_mem_w
    $error("fetch_assembler: MEM_W must be 8, 16 or 32");
  end
  if (INST_W % MEM_W != 0) begin : g_bad_inst_w
    $error("fetch_assembler: INST_W must be a multiple of MEM_W");
  end
  if (!(DEPTH == 2 || DEPTH == 4 || DEPTH == 8)) begin : g_bad_depth
    $error("fetch_assembler: DEPTH must be 2, 4 or 8");
  end
  if (FLUSH_GAP < 0 || FLUSH_GAP > 3) begin : g_bad_gap
    $error("fetch_assembler: FLUSH_GAP must be 0..3");
  end

  logic [BCW-1:0]    beat_cnt_q, beat_cnt_d;
  logic [INST_W-1:0] partial_q,  partial_d;
  logic [31:0]       pc0_q,      pc0_d;
  logic [PW-1:0]     wr_ptr_q,   wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q,   rd_ptr_d;
  logic [CW-1:0]     count_q,    count_d;
  logic [1:0]        gap_cnt_q,  gap_cnt_d;

  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [31:0]       pc_mem   [DEPTH];

  logic              pop;
  logic              accept;
  logic              last_beat;
  logic              push;
  logic [INST_W-1:0] word;
  logic [31:0]       word_pc;

  always_comb begin
    pop        = (count_q != '0) && id_ready;
    if_request = !rst && !jump && (gap_cnt_q == '0) &&
                 ((count_q < CW'(DEPTH)) || pop);
    accept     = if_valid && if_request;
    last_beat  = (beat_cnt_q == BCW'(BEATS - 1));
    push       = accept && last_beat;

    // The incoming beat is merged combinationally so the completed word can be
    // written into the FIFO on the same edge that accepts its last beat.
    word = partial_q;
    word[int'(beat_cnt_q) * MEM_W +: MEM_W] = if_data;
    word_pc = (beat_cnt_q == '0) ? if_pc : pc0_q;
  end

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    partial_d  = partial_q;
    pc0_d      = pc0_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    gap_cnt_d  = gap_cnt_q;

    if (jump) begin
      beat_cnt_d = '0;
      partial_d  = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      gap_cnt_d  = 2'(FLUSH_GAP);
    end else begin
      if (gap_cnt_q != '0) gap_cnt_d = gap_cnt_q - 2'd1;

      if (accept) begin
        if (beat_cnt_q == '0) pc0_d = if_pc;
        if (last_beat) begin
          beat_cnt_d = '0;
          partial_d  = '0;
        end else begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          partial_d  = word;
        end
      end

      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_q <= '0;
      partial_q  <= '0;
      pc0_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      gap_cnt_q  <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      partial_q  <= partial_d;
      pc0_q      <= pc0_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  // NOTE: the FIFO storage has no reset; an entry is only ever observed while
  // count_q marks it valid, and the outputs are forced to zero otherwise.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr_q] <= word;
      pc_mem[wr_ptr_q]   <= word_pc;
    end
  end

  always_comb begin
    id_valid     = (count_q != '0);
    id_inst      = id_valid ? inst_mem[rd_ptr_q] : '0;
    id_pc        = id_valid ? pc_mem[rd_ptr_q]   : '0;
    if_stall_req = (count_q == CW'(DEPTH));
  end

`ifdef FETCH_FLUSH_CNT_EN
  logic [15:0] flush_cnt_q, flush_cnt_d;

  // Only jumps that actually throw away fetched work are counted.
  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (jump && ((count_q != '0) || (beat_cnt_q != '0)) && (flush_cnt_q != 16'hFFFF))
      flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) flush_cnt_q <= '0;
    else     flush_cnt_q <= flush_cnt_d;
  end

  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_assembler.sv
// Bench for fetch_assembler: default instance checked against a queue-based
// reference model, plus 16-bit/DEPTH=2 and 32-bit-beat instances for directed cases.
module tb_fetch_assembler;

  localparam int BEATS     = 4;
  localparam int DEPTH     = 4;
  localparam int FLUSH_GAP = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [31:0] if_pc;
  logic [7:0]  if_data;
  logic        if_valid, jump, id_ready;
  logic        if_request, id_valid, if_stall_req;
  logic [31:0] id_inst, id_pc;

  logic [31:0] b_pc;
  logic [15:0] b_data;
  logic        b_valid, b_jump, b_ready;
  logic        b_req, b_id_valid, b_stall;
  logic [31:0] b_inst, b_id_pc;

  logic [31:0] c_pc;
  logic [31:0] c_data;
  logic        c_valid, c_jump, c_ready;
  logic        c_req, c_id_valid, c_stall;
  logic [31:0] c_inst, c_id_pc;

`ifdef FETCH_FLUSH_CNT_EN
  logic [15:0] flush_cnt, b_flush_cnt, c_flush_cnt;
`endif

  fetch_assembler u_dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_data(if_data), .if_valid(if_valid),
    .jump(jump), .id_ready(id_ready), .if_request(if_request), .id_valid(id_valid),
    .id_inst(id_inst), .id_pc(id_pc), .if_stall_req(if_stall_req)
`ifdef FETCH_FLUSH_CNT_EN
    , .flush_cnt(flush_cnt)
`endif
  );

  fetch_assembler #(.MEM_W(16), .INST_W(32), .DEPTH(2), .FLUSH_GAP(1)) u_dut16 (
    .clk(clk), .rst(rst), .if_pc(b_pc), .if_data(b_data), .if_valid(b_valid),
    .jump(b_jump), .id_ready(b_ready), .if_request(b_req), .id_valid(b_id_valid),
    .id_inst(b_inst), .id_pc(b_id_pc), .if_stall_req(b_stall)
`ifdef FETCH_FLUSH_CNT_EN
    , .flush_cnt(b_flush_cnt)
`endif
  );

  fetch_assembler #(.MEM_W(32), .INST_W(32), .DEPTH(4), .FLUSH_GAP(1)) u_dut32 (
    .clk(clk), .rst(rst), .if_pc(c_pc), .if_data(c_data), .if_valid(c_valid),
    .jump(c_jump), .id_ready(c_ready), .if_request(c_req), .id_valid(c_id_valid),
    .id_inst(c_inst), .id_pc(c_id_pc), .if_stall_req(c_stall)
`ifdef FETCH_FLUSH_CNT_EN
    , .flush_cnt(c_flush_cnt)
`endif
  );

  int n_err    = 0;
  int n_checks = 0;

  // Reference model: instruction queue, pending beats of the current word, gap timer.
  logic [31:0] mq_inst [$];
  logic [31:0] mq_pc   [$];
  logic [7:0]  mbeats  [$];
  logic [31:0] mpc0;
  int          mgap;
  int          mflush;

  // Upstream beat stream waiting to be accepted.
  logic [7:0]  pend_d  [$];
  logic [31:0] pend_pc [$];
  logic        valid_en;
  logic [31:0] pc_next;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq_inst.delete();
    mq_pc.delete();
    mbeats.delete();
    mgap = 0;
  endtask

  task automatic queue_inst(input logic [31:0] pc, input logic [31:0] w);
    for (int k = 0; k < BEATS; k++) begin
      pend_d.push_back(w[8*k +: 8]);
      pend_pc.push_back(pc + 32'(k));
    end
  endtask

  // One clock of the default instance: drive, check against model at negedge, update model at posedge.
  task automatic cycle();
    logic        exp_req, acc, pop;
    logic [31:0] w, head_inst, head_pc;
    acc      = 1'b0;
    if_valid = valid_en && (pend_d.size() > 0);
    if_data  = if_valid ? pend_d[0]  : 8'h00;
    if_pc    = if_valid ? pend_pc[0] : 32'h0;
    @(negedge clk);
    exp_req = !rst && !jump && (mgap == 0) &&
              ((mq_inst.size() < DEPTH) || ((mq_inst.size() > 0) && id_ready));
    head_inst = 32'h0;
    head_pc   = 32'h0;
    if (mq_inst.size() > 0) begin
      head_inst = mq_inst[0];
      head_pc   = mq_pc[0];
    end
    check("if_request", if_request, exp_req);
    check("id_valid", id_valid, mq_inst.size() > 0);
    check("id_inst", id_inst, head_inst);
    check("id_pc", id_pc, head_pc);
    check("if_stall_req", if_stall_req, mq_inst.size() == DEPTH);
`ifdef FETCH_FLUSH_CNT_EN
    check("flush_cnt", flush_cnt, mflush);
`endif
    @(posedge clk);
    if (rst) begin
      model_clear();
      mflush = 0;
    end else if (jump) begin
      if (((mq_inst.size() > 0) || (mbeats.size() > 0)) && (mflush < 65535)) mflush++;
      model_clear();
      mgap = FLUSH_GAP;
    end else begin
      pop = (mq_inst.size() > 0) && id_ready;
      acc = if_valid && exp_req;
      if (pop) begin
        mq_inst.delete(0);
        mq_pc.delete(0);
      end
      if (mgap > 0) mgap--;
      if (acc) begin
        if (mbeats.size() == 0) mpc0 = if_pc;
        mbeats.push_back(if_data);
        if (mbeats.size() == BEATS) begin
          w = 32'h0;
          foreach (mbeats[k]) w = w + (32'(mbeats[k]) << (8 * k));
          mq_inst.push_back(w);
          mq_pc.push_back(mpc0);
          mbeats.delete();
        end
      end
    end
    if (acc) begin
      pend_d.delete(0);
      pend_pc.delete(0);
    end
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic drain(input int max_cycles);
    int i = 0;
    while ((pend_d.size() > 0) && (i < max_cycles)) begin
      cycle();
      i++;
    end
    check("drain_bound", pend_d.size(), 0);
  endtask

  initial begin
    rst = 1'b1; jump = 1'b0; id_ready = 1'b0; valid_en = 1'b0;
    if_valid = 1'b0; if_data = '0; if_pc = '0;
    b_valid = 1'b0; b_jump = 1'b0; b_ready = 1'b0; b_data = '0; b_pc = '0;
    c_valid = 1'b0; c_jump = 1'b0; c_ready = 1'b0; c_data = '0; c_pc = '0;
    mpc0 = '0; mflush = 0; pc_next = 32'h2000;
    model_clear();

    // Reset state.
    #2;
    check("rst_if_request", if_request, 1'b0);
    check("rst_id_valid", id_valid, 1'b0);
    check("rst_id_inst", id_inst, 32'h0);
    check("rst_id_pc", id_pc, 32'h0);
    check("rst_stall", if_stall_req, 1'b0);
    check("rst_b_req", b_req, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    #0;
    check("req_after_rst", if_request, 1'b1);
    check("b_req_after_rst", b_req, 1'b1);

    // 16-bit beats, DEPTH=2.
    b_ready = 1'b1; b_valid = 1'b1; b_data = 16'h0513; b_pc = 32'h100;
    @(posedge clk); #1;
    b_data = 16'h0010; b_pc = 32'h102;
    check("b_req_beat1", b_req, 1'b1);
    check("b_valid_partial", b_id_valid, 1'b0);
    @(posedge clk); #1;
    b_valid = 1'b0;
    check("b_valid", b_id_valid, 1'b1);
    check("b_inst", b_inst, 32'h00100513);
    check("b_pc", b_id_pc, 32'h100);
    @(posedge clk); #1;
    check("b_popped", b_id_valid, 1'b0);
    b_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b_valid = 1'b1; b_data = 16'(i + 1); b_pc = 32'h200 + 32'(2 * i);
      @(posedge clk); #1;
    end
    b_valid = 1'b0;
    check("b_stall_full", b_stall, 1'b1);
    check("b_req_full", b_req, 1'b0);
    check("b_head_inst", b_inst, 32'h00020001);
    check("b_head_pc", b_id_pc, 32'h200);
    b_ready = 1'b1;
    @(posedge clk); #1;
    check("b_second_inst", b_inst, 32'h00040003);
    check("b_second_pc", b_id_pc, 32'h204);
    @(posedge clk); #1;
    check("b_empty", b_id_valid, 1'b0);
    b_ready = 1'b0;

    // 32-bit beats: push of a completed word and pop together while full.
    for (int i = 0; i < 4; i++) begin
      c_valid = 1'b1; c_data = 32'hA0 + 32'(i); c_pc = 32'h10 * 32'(i);
      @(posedge clk); #1;
    end
    check("c_stall_full", c_stall, 1'b1);
    check("c_req_full", c_req, 1'b0);
    check("c_head_full", c_inst, 32'hA0);
    c_ready = 1'b1; c_data = 32'hA4; c_pc = 32'h40;
    #0;
    check("c_req_pop", c_req, 1'b1);
    @(posedge clk); #1;
    c_valid = 1'b0;
    check("c_stall_kept", c_stall, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      check("c_drain_inst", c_inst, 32'hA0 + 32'(i));
      check("c_drain_pc", c_id_pc, 32'h10 * 32'(i));
      @(posedge clk); #1;
    end
    check("c_empty", c_id_valid, 1'b0);
    c_ready = 1'b0;

    // First instruction, one-cycle latency.
    id_ready = 1'b1; valid_en = 1'b1;
    queue_inst(32'h0, 32'h00100513);
    drain(20);
    check("first_valid", id_valid, 1'b1);
    check("first_inst", id_inst, 32'h00100513);
    check("first_pc", id_pc, 32'h0);
    run(2);

    // Back-pressure: five instructions with decode stalled.
    id_ready = 1'b0;
    for (int i = 0; i < 5; i++) queue_inst(32'h1000 + 32'(16 * i), $urandom);
    run(24);
    check("full_stall", if_stall_req, 1'b1);
    check("full_no_req", if_request, 1'b0);
    id_ready = 1'b1;
    drain(40);
    run(8);

    // Jump with two entries buffered and a half-built word.
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) queue_inst(32'h3000 + 32'(4 * i), $urandom);
    run(10);
    jump = 1'b1;
    cycle();
    jump = 1'b0;
    pend_d.delete();
    pend_pc.delete();
    #0;
    check("jump_valid", id_valid, 1'b0);
    check("jump_gap_req", if_request, 1'b0);
`ifdef FETCH_FLUSH_CNT_EN
    check("jump_flush_cnt", flush_cnt, 16'd1);
`endif
    cycle();
    check("jump_req_back", if_request, 1'b1);

    // Randomized traffic with occasional redirects.
    for (int c = 0; c < 800; c++) begin
      if ((pend_d.size() == 0) && ($urandom_range(2) != 0)) begin
        queue_inst(pc_next, $urandom);
        pc_next = pc_next + 32'd4;
      end
      valid_en = ($urandom_range(3) != 0);
      id_ready = (c < 400) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
      jump     = ($urandom_range(29) == 0);
      cycle();
      if (jump) begin
        pend_d.delete();
        pend_pc.delete();
        pc_next = $urandom & 32'hFFFF_FFFC;
      end
    end
    jump = 1'b0;

    // Asynchronous reset with three entries and a partial word.
    pend_d.delete();
    pend_pc.delete();
    id_ready = 1'b1;
    run(6);
    id_ready = 1'b0; valid_en = 1'b1;
    for (int i = 0; i < 4; i++) queue_inst(32'h5000 + 32'(4 * i), $urandom);
    run(14);
    check("pre_rst_valid", id_valid, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_valid", id_valid, 1'b0);
    check("async_rst_stall", if_stall_req, 1'b0);
    check("async_rst_req", if_request, 1'b0);
    check("async_rst_inst", id_inst, 32'h0);
    model_clear();
    mflush = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    pend_d.delete();
    pend_pc.delete();
    queue_inst(32'h400, 32'hDEADBEEF);
    drain(10);
    check("post_rst_inst", id_inst, 32'hDEADBEEF);
    check("post_rst_pc", id_pc, 32'h400);
`ifdef FETCH_FLUSH_CNT_EN
    check("post_rst_flush", flush_cnt, 16'd0);
`endif
    run(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
